// File: rtl/npu_axil_cfg_master_if.sv
// npu_axil_cfg_master_if: job command, AXI-Lite initiator channels and completion response
interface npu_axil_cfg_master_if #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [3:0]                    cmd_cluster_en;
    logic [15:0]                   cmd_pe_en;
    logic [AXI_DATA_WIDTH-1:0]     cmd_config;
    logic [AXI_DATA_WIDTH-1:0]     cmd_dim_m;
    logic [AXI_DATA_WIDTH-1:0]     cmd_dim_k;
    logic [AXI_DATA_WIDTH-1:0]     cmd_dim_n;
    logic [AXI_DATA_WIDTH-1:0]     cmd_addr_input;
    logic [AXI_DATA_WIDTH-1:0]     cmd_addr_weight;
    logic [AXI_DATA_WIDTH-1:0]     cmd_addr_output;
    logic [AXI_ADDR_WIDTH-1:0]     m_awaddr;
    logic                          m_awvalid;
    logic                          m_awready;
    logic [AXI_DATA_WIDTH-1:0]     m_wdata;
    logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb;
    logic                          m_wvalid;
    logic                          m_wready;
    logic [1:0]                    m_bresp;
    logic                          m_bvalid;
    logic                          m_bready;
    logic [AXI_ADDR_WIDTH-1:0]     m_araddr;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [AXI_DATA_WIDTH-1:0]     m_rdata;
    logic [1:0]                    m_rresp;
    logic                          m_rvalid;
    logic                          m_rready;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [1:0]                    rsp_code;
    logic [AXI_DATA_WIDTH-1:0]     rsp_status;

    modport master (
        input  cmd_valid, cmd_cluster_en, cmd_pe_en, cmd_config, cmd_dim_m, cmd_dim_k, cmd_dim_n,
               cmd_addr_input, cmd_addr_weight, cmd_addr_output,
        output cmd_ready,
        output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
        output rsp_valid, rsp_code, rsp_status,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_cluster_en, cmd_pe_en, cmd_config, cmd_dim_m, cmd_dim_k, cmd_dim_n,
               cmd_addr_input, cmd_addr_weight, cmd_addr_output,
        input  cmd_ready,
        input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
        input  rsp_valid, rsp_code, rsp_status,
        output rsp_ready
    );
endinterface

// File: rtl/npu_axil_cfg_master.sv
// npu_axil_cfg_master: programs the NPU register block over AXI-Lite from one latched job, then polls for completion
module npu_axil_cfg_master #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int POLL_GAP       = 4,
    parameter int TIMEOUT_POLLS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    npu_axil_cfg_master_if.master bus,
    output logic                  busy_o
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam int PW = $clog2(TIMEOUT_POLLS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(TIMEOUT_POLLS);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, GAP, RD_REQ, RD_RESP, RSP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic            issued_q, issued_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   status_q, status_d;
    logic [1:0]      code_q, code_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [PW-1:0]   poll_inc;
    logic [DW-1:0]   cfg_q [12];
    logic            cmd_fire;

    assign cmd_fire = state_q == IDLE && bus.cmd_valid;
    assign poll_inc = poll_q + 1'b1;

    // Setup register images in write order: CLUSTER_EN, PE_EN_0..3, CONFIG, DIM_M/K/N, ADDR_INPUT/WEIGHT/OUTPUT
    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            cfg_q[0] <= DW'(bus.cmd_cluster_en);
            for (int i = 0; i < 4; i++) cfg_q[1+i] <= DW'(bus.cmd_pe_en[4*i +: 4]);
            cfg_q[5]  <= bus.cmd_config;
            cfg_q[6]  <= bus.cmd_dim_m;
            cfg_q[7]  <= bus.cmd_dim_k;
            cfg_q[8]  <= bus.cmd_dim_n;
            cfg_q[9]  <= bus.cmd_addr_input;
            cfg_q[10] <= bus.cmd_addr_weight;
            cfg_q[11] <= bus.cmd_addr_output;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            issued_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            status_q  <= '0;
            code_q    <= '0;
            gap_q     <= '0;
            poll_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            issued_q  <= issued_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            status_q  <= status_d;
            code_q    <= code_d;
            gap_q     <= gap_d;
            poll_q    <= poll_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        issued_d  = issued_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        status_d  = status_q;
        code_d    = code_q;
        gap_d     = gap_q;
        poll_d    = poll_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                idx_d    = '0;
                issued_d = 1'b0;
                code_d   = '0;
                status_d = '0;
                state_d  = WR_REQ;
            end
            WR_REQ: if (!issued_q) begin
                issued_d  = 1'b1;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = idx_q < 4'd12 ? AW'({idx_q, 2'b00}) + AW'(8) : '0;
                wdata_d   = idx_q < 4'd12 ? cfg_q[idx_q] : (idx_q == 4'd12 ? DW'(1) : DW'(2));
            end else begin
                awvalid_d = awvalid_q && !bus.m_awready;
                wvalid_d  = wvalid_q && !bus.m_wready;
                if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: if (bus.m_bvalid) begin
                if (bus.m_bresp != 2'b00) begin
                    code_d  = 2'd2;
                    state_d = RSP;
                end else if (idx_q < 4'd12) begin
                    idx_d    = idx_q + 4'd1;
                    issued_d = 1'b0;
                    state_d  = WR_REQ;
                end else if (idx_q == 4'd12) begin
                    poll_d  = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    state_d = RSP;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    issued_d = 1'b0;
                    state_d  = RD_REQ;
                end
            end
            RD_REQ: if (!issued_q) begin
                issued_d  = 1'b1;
                arvalid_d = 1'b1;
            end else if (bus.m_arready) begin
                arvalid_d = 1'b0;
                state_d   = RD_RESP;
            end
            RD_RESP: if (bus.m_rvalid) begin
                if (bus.m_rresp != 2'b00) begin
                    code_d  = 2'd2;
                    state_d = RSP;
                end else begin
                    status_d = bus.m_rdata;
                    poll_d   = poll_inc;
                    // Error wins over done; both still finish with the CTRL clear write
                    if (bus.m_rdata[2] || bus.m_rdata[1]) begin
                        code_d   = bus.m_rdata[2] ? 2'd1 : 2'd0;
                        idx_d    = 4'd13;
                        issued_d = 1'b0;
                        state_d  = WR_REQ;
                    end else if (poll_inc == POLL_MAX) begin
                        code_d  = 2'd3;
                        state_d = RSP;
                    end else begin
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            RSP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready  = state_q == IDLE;
    assign bus.m_awaddr   = awaddr_q;
    assign bus.m_awvalid  = awvalid_q;
    assign bus.m_wdata    = wdata_q;
    assign bus.m_wstrb    = '1;
    assign bus.m_wvalid   = wvalid_q;
    assign bus.m_bready   = state_q == WR_RESP;
    assign bus.m_araddr   = arvalid_q ? AW'(4) : '0;
    assign bus.m_arvalid  = arvalid_q;
    assign bus.m_rready   = state_q == RD_RESP;
    assign bus.rsp_valid  = state_q == RSP;
    assign bus.rsp_code   = code_q;
    assign bus.rsp_status = status_q;
    assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_npu_axil_cfg_master.sv
// tb_npu_axil_cfg_master: randomized jobs against an AXI-Lite register-block responder and a job-level reference model
module tb_npu_axil_cfg_master;
    localparam int PG = 4;
    localparam int TP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    npu_axil_cfg_master_if #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)) bus ();

    npu_axil_cfg_master #(
        .AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32), .POLL_GAP(PG), .TIMEOUT_POLLS(TP)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // responder state and observations
    int          mode;
    logic [11:0] err_addr;
    logic [31:0] stat_src[$];
    logic [31:0] stat_q[$];
    logic [11:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          rd_cnt, prot_err, min_gap, last_r, cyc;
    int          aw_wait, w_wait, ar_wait;
    bit          aw_got, w_got, ar_got, b_fire, r_fire, aw_pend, w_pend, ar_pend;
    logic [11:0] cur_addr, aw_hold;
    logic [31:0] cur_data, w_hold;

    // reference model state
    logic [31:0] cfgv[12];
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_reads;
    logic [1:0]  exp_code;
    logic [31:0] exp_status;

    function automatic int pick_wait(input bit is_aw);
        if (mode == 2) return is_aw ? 3 : 0;
        if (mode == 1) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic slave_clear();
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
        bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
        aw_wait = pick_wait(1); w_wait = pick_wait(0); ar_wait = pick_wait(0);
    endtask

    initial begin
        cyc = 0;
        mode = 0;
        last_r = 0;
        slave_clear();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                slave_clear();
                continue;
            end
            if (b_fire) begin bus.m_bvalid = 0; aw_got = 0; w_got = 0; b_fire = 0; end
            if (r_fire) begin bus.m_rvalid = 0; r_fire = 0; end
            if (aw_pend && (!bus.m_awvalid || bus.m_awaddr !== aw_hold)) prot_err++;
            if (w_pend && (!bus.m_wvalid || bus.m_wdata !== w_hold)) prot_err++;
            if (ar_pend && !bus.m_arvalid) prot_err++;
            if (aw_got && w_got && !bus.m_bvalid) begin
                bus.m_bvalid = 1;
                bus.m_bresp  = cur_addr == err_addr ? 2'b10 : 2'b00;
                obs_addr.push_back(cur_addr);
                obs_data.push_back(cur_data);
            end
            b_fire = bus.m_bvalid && bus.m_bready;
            bus.m_awready = 0;
            if (bus.m_awvalid) begin
                if (aw_got) prot_err++;
                else if (aw_wait > 0) aw_wait--;
                else begin bus.m_awready = 1; aw_got = 1; cur_addr = bus.m_awaddr; aw_wait = pick_wait(1); end
            end
            aw_pend = bus.m_awvalid && !bus.m_awready;
            aw_hold = bus.m_awaddr;
            bus.m_wready = 0;
            if (bus.m_wvalid) begin
                if (w_got) prot_err++;
                else if (w_wait > 0) w_wait--;
                else begin
                    bus.m_wready = 1; w_got = 1; cur_data = bus.m_wdata; w_wait = pick_wait(0);
                    if (bus.m_wstrb !== 4'hF) prot_err++;
                end
            end
            w_pend = bus.m_wvalid && !bus.m_wready;
            w_hold = bus.m_wdata;
            if (ar_got && !bus.m_rvalid) begin
                bus.m_rvalid = 1;
                bus.m_rresp  = 0;
                bus.m_rdata  = stat_q.size() > 0 ? stat_q[0] : 32'h0;
                if (stat_q.size() > 1) void'(stat_q.pop_front());
                ar_got = 0;
            end
            r_fire = bus.m_rvalid && bus.m_rready;
            if (r_fire) last_r = cyc;
            bus.m_arready = 0;
            if (bus.m_arvalid) begin
                if (!ar_pend && rd_cnt > 0 && cyc - last_r - 1 < min_gap) min_gap = cyc - last_r - 1;
                if (ar_got || bus.m_araddr !== 12'h004) prot_err++;
                else if (ar_wait > 0) ar_wait--;
                else begin bus.m_arready = 1; ar_got = 1; rd_cnt++; ar_wait = pick_wait(0); end
            end
            ar_pend = bus.m_arvalid && !bus.m_arready;
        end
    end

    task automatic new_cmd();
        bus.cmd_cluster_en  = 4'($urandom);
        bus.cmd_pe_en       = 16'($urandom);
        bus.cmd_config      = $urandom;
        bus.cmd_dim_m       = $urandom;
        bus.cmd_dim_k       = $urandom;
        bus.cmd_dim_n       = $urandom;
        bus.cmd_addr_input  = $urandom;
        bus.cmd_addr_weight = $urandom;
        bus.cmd_addr_output = $urandom;
        cfgv[0] = {28'h0, bus.cmd_cluster_en};
        for (int i = 0; i < 4; i++) cfgv[1+i] = {28'h0, bus.cmd_pe_en[4*i +: 4]};
        cfgv[5]  = bus.cmd_config;
        cfgv[6]  = bus.cmd_dim_m;
        cfgv[7]  = bus.cmd_dim_k;
        cfgv[8]  = bus.cmd_dim_n;
        cfgv[9]  = bus.cmd_addr_input;
        cfgv[10] = bus.cmd_addr_weight;
        cfgv[11] = bus.cmd_addr_output;
    endtask

    // Job outcome: the write list, the number of STATUS reads and the response
    task automatic build_exp();
        exp_addr.delete();
        exp_data.delete();
        exp_reads  = 0;
        exp_code   = 0;
        exp_status = 0;
        for (int i = 0; i < 13; i++) begin
            logic [11:0] a;
            a = i < 12 ? 12'(8 + 4 * i) : 12'h000;
            exp_addr.push_back(a);
            exp_data.push_back(i < 12 ? cfgv[i] : 32'h1);
            if (a == err_addr) begin exp_code = 2; return; end
        end
        for (int p = 0; p < TP; p++) begin
            logic [31:0] s;
            s = stat_src[p < stat_src.size() ? p : stat_src.size() - 1];
            exp_reads++;
            exp_status = s;
            if (s[2] || s[1]) begin
                exp_code = s[2] ? 2'd1 : 2'd0;
                exp_addr.push_back(12'h000);
                exp_data.push_back(32'h2);
                return;
            end
        end
        exp_code = 3;
    endtask

    task automatic arm(input int m, input logic [11:0] ea);
        mode     = m;
        err_addr = ea;
        stat_q   = stat_src;
        obs_addr.delete();
        obs_data.delete();
        rd_cnt   = 0;
        prot_err = 0;
        min_gap  = 1000;
        aw_wait  = pick_wait(1);
        w_wait   = pick_wait(0);
        ar_wait  = pick_wait(0);
    endtask

    task automatic send_cmd(input string tag);
        int n = 0;
        bus.cmd_valid = 1;
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.cmd_valid = 0;
        check({tag, "_accept"}, {31'h0, busy}, 32'h1);
    endtask

    task automatic finish_job(input string tag, input int hold, input bit next_cmd);
        int n = 0;
        int nw;
        while (!bus.rsp_valid && n < 5000) begin @(negedge clk); n++; end
        check({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
        check({tag, "_code"}, {30'h0, bus.rsp_code}, {30'h0, exp_code});
        check({tag, "_status"}, bus.rsp_status, exp_status);
        check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
        nw = obs_addr.size() < exp_addr.size() ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), {20'h0, obs_addr[i]}, {20'h0, exp_addr[i]});
            check($sformatf("%s_wdata%0d", tag, i), obs_data[i], exp_data[i]);
        end
        check({tag, "_reads"}, rd_cnt, exp_reads);
        check({tag, "_protocol"}, prot_err, 0);
        if (exp_reads > 1) check({tag, "_poll_gap"}, {31'h0, min_gap >= PG}, 32'h1);
        if (next_cmd) bus.cmd_valid = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("%s_hold%0d", tag, i), {bus.rsp_valid, bus.cmd_ready, bus.rsp_code, bus.rsp_status[27:0]},
                  {1'b1, 1'b0, exp_code, exp_status[27:0]});
        end
        bus.rsp_ready = 1;
        @(negedge clk);
        bus.rsp_ready = 0;
        check({tag, "_rsp_done"}, {30'h0, bus.rsp_valid, bus.cmd_ready}, 32'h1);
        if (next_cmd) begin
            arm(mode, err_addr);
            @(negedge clk);
            bus.cmd_valid = 0;
            check({tag, "_next_accept"}, {30'h0, busy, bus.cmd_ready}, 32'h2);
        end
    endtask

    task automatic run_job(input string tag, input int m, input logic [11:0] ea, input int hold, input bit next_cmd);
        new_cmd();
        err_addr = ea;
        build_exp();
        arm(m, ea);
        send_cmd(tag);
        finish_job(tag, hold, next_cmd);
        if (next_cmd) finish_job({tag, "_2nd"}, 0, 0);
    endtask

    function automatic logic [31:0] rand_status();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 0) return ($urandom & ~32'h4) | 32'h2;
        if (r == 1) return $urandom | 32'h4;
        return $urandom & ~32'h6;
    endfunction

    initial begin
        int n;
        logic [11:0] ea;
        bus.cmd_valid = 0;
        bus.rsp_ready = 0;
        new_cmd();
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        check("rst_valids", {25'h0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready,
                             bus.m_rready, bus.rsp_valid, busy}, 32'h0);
        check("rst_rsp_code", {30'h0, bus.rsp_code}, 32'h0);
        check("rst_rsp_status", bus.rsp_status, 32'h0);
        check("rst_awaddr", {20'h0, bus.m_awaddr}, 32'h0);
        check("rst_wdata", bus.m_wdata, 32'h0);
        rst = 0;
        @(negedge clk);
        stat_src = '{32'h2};
        run_job("nominal", 0, 12'hFFF, 0, 0);
        run_job("aw_late", 2, 12'hFFF, 0, 0);
        run_job("bresp_err", 0, 12'h024, 0, 0);
        stat_src = '{32'h1, 32'h1, 32'h5};
        run_job("npu_err", 1, 12'hFFF, 0, 0);
        stat_src = '{32'h1};
        run_job("timeout", 0, 12'hFFF, 0, 0);
        stat_src = '{32'h2};
        run_job("hold", 1, 12'hFFF, 10, 1);
        for (int j = 0; j < 25; j++) begin
            stat_src.delete();
            for (int k = 0; k < int'($urandom_range(1, TP + 1)); k++) stat_src.push_back(rand_status());
            ea = $urandom_range(0, 3) == 0 ? 12'(8 + 4 * $urandom_range(0, 11)) : 12'hFFF;
            run_job($sformatf("rand%0d", j), int'($urandom_range(0, 1)), ea, int'($urandom_range(0, 3)), 0);
        end
        stat_src = '{32'h2};
        new_cmd();
        arm(0, 12'hFFF);
        bus.cmd_valid = 1;
        n = 0;
        while (!bus.m_awvalid && n < 20) begin @(negedge clk); n++; end
        check("midrst_reached", {31'h0, bus.m_awvalid}, 32'h1);
        rst = 1;
        bus.cmd_valid = 0;
        @(negedge clk);
        check("midrst_valids", {26'h0, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.rsp_valid, busy,
                                bus.cmd_ready}, 32'h1);
        rst = 0;
        @(negedge clk);
        run_job("after_rst", 0, 12'hFFF, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/npu_axil_cfg_master.md
Name: npu_axil_cfg_master

Overview:
- AXI-Lite initiator that programs the NPU register block (the AXI-Lite responder) from a single latched job command.
- Writes the 12 setup registers, writes CTRL.start, polls STATUS until done or error, writes CTRL.clear, then returns a completion response.
- Sits between the host command queue/sequencer and the NPU control slave.

Parameters:
- AXI_ADDR_WIDTH, 12, AXI-Lite address width.
- AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- POLL_GAP, 4, idle cycles between consecutive STATUS reads (must be ≥1).
- TIMEOUT_POLLS, 1024, maximum STATUS reads before timeout (must be ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_cluster_en  in  4  value for CLUSTER_EN
- cmd_pe_en  in  16  nibble i → PE_EN_i
- cmd_config, cmd_dim_m, cmd_dim_k, cmd_dim_n  in  32 each  CONFIG / DIM_M / DIM_K / DIM_N values
- cmd_addr_input, cmd_addr_weight, cmd_addr_output  in  32 each  ADDR_INPUT / ADDR_WEIGHT / ADDR_OUTPUT values
- m_awaddr, m_awvalid, m_awready  out, out, in  12, 1, 1  write address channel
- m_wdata, m_wstrb, m_wvalid, m_wready  out, out, out, in  32, 4, 1, 1  write data channel
- m_bresp, m_bvalid, m_bready  in, in, out  2, 1, 1  write response channel
- m_araddr, m_arvalid, m_arready  out, out, in  12, 1, 1  read address channel
- m_rdata, m_rresp, m_rvalid, m_rready  in, in, in, out  32, 2, 1, 1  read data channel
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_code  out  2  0=done, 1=NPU error, 2=bus error, 3=timeout
- rsp_status  out  32  last STATUS word read (0 if none)
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (synchronous, rst=1): state=IDLE. All m_*valid, m_bready, m_rready, rsp_valid and busy = 0. cmd_ready=1 from the first cycle after reset. rsp_code=0, rsp_status=0, addresses/wdata=0.
- Reset mid-transaction drops all valids immediately, with no completion; system integration resets the slave together with this block.
- States: IDLE, WR_REQ, WR_RESP, GAP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. A cmd_valid&cmd_ready handshake latches all cmd_* fields, sets idx=0 and goes to WR_REQ. cmd_ready is 0 in every other state.
- Write sequence idx 0..11: address 0x008+4*idx, giving CLUSTER_EN, PE_EN_0..3, CONFIG, DIM_M, DIM_K, DIM_N, ADDR_INPUT, ADDR_WEIGHT, ADDR_OUTPUT.
- idx 12 writes CTRL (0x000) = 0x1 (start). idx 13 writes CTRL = 0x2 (clear).
- Write data for CLUSTER_EN and PE_EN_i is zero-extended from 4 bits. m_wstrb=4'hF always.
- WR_REQ: m_awvalid and m_wvalid both rise in the cycle after entry. Each stays high until its own ready is sampled high; the two channels are independent, and the same cycle or either order is allowed. When both have been accepted, go to WR_RESP. No new AW/W is issued before B completes, so at most one transaction is outstanding.
- WR_RESP: m_bready=1. On m_bvalid:
  - bresp≠0 → rsp_code=2, go to RSP.
  - idx≤11 → idx++, WR_REQ.
  - idx=12 → poll_cnt=0, GAP.
  - idx=13 → RSP, keeping the already set rsp_code.
- GAP: counts POLL_GAP cycles, then RD_REQ.
- RD_REQ: m_araddr=0x004; m_arvalid is held until m_arready, then RD_RESP.
- RD_RESP: m_rready=1. On m_rvalid:
  - rresp≠0 → rsp_code=2, RSP.
  - Otherwise rsp_status←m_rdata and poll_cnt++.
  - If rdata[2] (error) → rsp_code=1, idx=13, WR_REQ. Error takes priority if done and error are both set.
  - Else if rdata[1] (done) → rsp_code=0, idx=13, WR_REQ.
  - Else if poll_cnt reaches TIMEOUT_POLLS → rsp_code=3, RSP; no clear write is issued.
  - Else → GAP.
- RSP: rsp_valid=1, with rsp_code and rsp_status stable until rsp_ready. On the handshake cycle → IDLE; cmd_ready is high the next cycle.
- Valids never drop before their ready, and payloads stay stable while valid is high.
- Minimum latency, with all readies tied high and done seen on the first poll: 14 writes × 3 cycles + POLL_GAP + 3 + 1 cycles.

Test Plan:
- Nominal, all readies high, STATUS=0x2 on the first read → 14 writes to 0x008..0x034, 0x000=0x1, 0x000=0x2 in order; rsp_code=0, rsp_status=0x2.
- m_wready asserted 3 cycles before m_awready on every write → AW held until accepted, W dropped after its accept, each write issued exactly once, same address/data order.
- bresp=2'b10 on the DIM_K write (0x024) → no further AW/AR issued; rsp_code=2, rsp_status=0.
- STATUS reads 0x1,0x1,0x5 → exactly 3 reads spaced ≥POLL_GAP idle cycles; CTRL clear written; rsp_code=1, rsp_status=0x5.
- TIMEOUT_POLLS=4, STATUS always 0x1 → exactly 4 reads, no clear write, rsp_code=3, rsp_status=0x1.
- rsp_ready held low 10 cycles while a new cmd_valid is presented → rsp_valid and payload stable, cmd_ready=0 throughout; the second command is accepted in the cycle after the rsp handshake. Reset asserted mid-WR_REQ → all valids 0 the next cycle and cmd_ready=1.
